vospi_packet_tx: RTL and testbench
==================================

Name: vospi_packet_tx

Overview:
- Transmit-side counterpart of the VoSPI packet receiver; models the camera end of the link for loopback and simulation.
- Buffers one line of payload bytes and computes its CRC-16 while loading.
- Serialises the packet, MSB first, on miso_o, one bit per shift_i strobe from the synchronous SPI slave front end.
- Packet format: ID (2 bytes), CRC (2 bytes), payload (payload_bytes_p bytes).

Parameters:
- payload_bytes_p, 160, payload bytes per packet.
- line_width_p, 12, width of the line number field in the ID; the upper ID bits are zero.

Ports:
- clk_i  in  1  single system clock.
- reset_n_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  one-cycle pulse: begin a packet for line_id_i; ignored unless the block is IDLE.
- line_id_i  in  line_width_p  line number, captured on start_i.
- data_i  in  8  payload byte.
- valid_i  in  1  data_i valid.
- ready_o  out  1  byte accepted when valid_i and ready_o are both high.
- cs_n_i  in  1  chip select, already synchronised to clk_i.
- shift_i  in  1  one-cycle strobe per SPI bit (SCK falling edge, from the front end).
- miso_o  out  1  serial data, registered.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse after the last bit is shifted.

Behaviour:
- Reset: state IDLE; ready_o=0, miso_o=0, busy_o=0, done_o=0; counters and CRC cleared.
- CRC: CRC-16-CCITT, poly 0x1021, init 0x0000, no reflection, no final XOR, processed bytewise one byte per cycle.
- CRC coverage, in order: ID byte0 with its top 4 bits forced to zero, ID byte1, 0x00, 0x00, then the payload bytes.
- IDLE: on start_i, capture ID = zero-extended line_id_i, clear CRC, go to HDR.
- HDR: 4 cycles, feeding the 4 header bytes into the CRC; ready_o=0; then go to LOAD.
- LOAD: ready_o=1.
  - Each handshake writes the byte to the buffer at byte_cnt and updates the CRC.
  - After byte payload_bytes_p-1 is accepted: ready_o drops the next cycle; go to ARMED.
  - valid_i gaps stall the load without limit.
- ARMED:
  - Load the output shift register with ID byte0; miso_o presents bit 7.
  - shift_i is ignored while cs_n_i=1.
  - When cs_n_i=0, go to SEND.
- SEND:
  - Each shift_i advances miso_o by one bit on the following clock edge.
  - At each byte boundary, the next byte is taken in order: ID1, CRC[15:8], CRC[7:0], then buffer[0..payload_bytes_p-1].
  - The buffer read is registered, so the address for byte n+1 is issued during byte n.
  - Total bits per packet: 8*(4+payload_bytes_p), i.e. 1312 at default.
  - The shift_i that consumes the last bit: done_o pulses one cycle later; state goes to IDLE; miso_o goes to 0.
- Abort: cs_n_i rising during SEND rewinds to ARMED with the bit pointer at packet start; the next selection retransmits the full packet. Buffer and CRC are kept.
- Ignored inputs: start_i outside IDLE; shift_i outside SEND (and outside DISC when the optional feature is built).
- Reset mid-packet: the buffered packet is lost; no done_o.
- The buffer is a single bank: no loading is allowed during SEND.

Optional Feature:
- Macro: VOSPI_DISCARD_EN.
- Defined:
  - In IDLE with cs_n_i=0, the block enters DISC and transmits a discard packet: bytes 0x0F, 0x00, then 2+payload_bytes_p bytes of 0x00, using the same shift rules as SEND.
  - A start_i received during DISC is latched and honoured on return to IDLE.
  - cs_n_i high during DISC returns the block to IDLE.
  - done_o does not pulse for a discard packet.
- Undefined: no DISC state; miso_o holds 0 in IDLE regardless of shift_i.

Decomposition:
- Package vospi_pkg:
  - header_bytes_lp=4.
  - discard ID constant 16'h0F00.
  - CRC polynomial constant.
  - state enum {IDLE, HDR, LOAD, ARMED, SEND, DISC}.
  - function crc16_ccitt_byte(crc, byte) returning the next CRC.
- One sub-module: vospi_tx_buffer, a payload_bytes_p x 8 single-port RAM with synchronous read and write.

Test Plan:
- Full packet: start_i with line_id_i=12'h005, payload 0x00..0x9F, cs_n_i=0, 1312 shift_i -> first 16 bits 0x0005; bits 16..31 match a reference-model CRC; payload bits match; done_o pulses once.
- Load backpressure: valid_i toggled every other cycle -> all 160 bytes accepted in order; ready_o=0 in HDR and ARMED; CRC unchanged versus the gap-free run.
- CRC masking: line_id_i=12'hFFF -> ID bits 0x0FFF; CRC equals the model value computed with ID byte0=0x0F.
- Abort: cs_n_i raised after 500 shift_i, then lowered -> packet retransmitted from ID bit 15; total 1312 bits after reselect; single done_o.
- Async reset: reset_n_i low mid-SEND -> outputs reach reset values immediately; subsequent start_i produces a correct packet.
- With VOSPI_DISCARD_EN, cs_n_i=0 in IDLE, 1312 shift_i -> stream 0x0F, 0x00, then zeros; a start_i pulsed mid-discard -> the real packet is sent next.

Source files
------------

// File: rtl/vospi_pkg.sv
// Shared types, constants and the bytewise CRC-16-CCITT step for the VoSPI transmitter.
package vospi_pkg;

  localparam int          header_bytes_lp = 4;
  localparam logic [15:0] discard_id_lp   = 16'h0F00;
  localparam logic [15:0] crc_poly_lp     = 16'h1021;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    LOAD  = 3'd2,
    ARMED = 3'd3,
    SEND  = 3'd4,
    DISC  = 3'd5
  } state_e;

  // Unreflected CRC-16-CCITT, one byte per call, MSB of the byte first.
  function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      if (c[15]) begin
        c = {c[14:0], 1'b0} ^ crc_poly_lp;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/vospi_tx_buffer.sv
// One-line payload store: single-port RAM with synchronous write and registered read.
module vospi_tx_buffer #(
  parameter int depth_p  = 160,
  parameter int addr_w_p = 8
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                we_i,
  input  logic [addr_w_p-1:0] addr_i,
  input  logic [7:0]          wdata_i,
  output logic [7:0]          rdata_o
);

  logic [7:0] mem_q [depth_p];
  logic [7:0] rdata_q;

  // Storage array; no reset so it maps onto RAM macros.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdata_q <= 8'h00;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/vospi_packet_tx.sv
// VoSPI packet transmitter: buffers one line, computes its CRC, shifts the packet out MSB first.
// Optional discard-packet generation in IDLE is built when VOSPI_DISCARD_EN is defined.
module vospi_packet_tx
  import vospi_pkg::*;
#(
  parameter int payload_bytes_p = 160,
  parameter int line_width_p    = 12
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic [line_width_p-1:0] line_id_i,
  input  logic [7:0]              data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    cs_n_i,
  input  logic                    shift_i,
  output logic                    miso_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int total_bits_lp = 8 * (header_bytes_lp + payload_bytes_p);
  localparam int bit_w_lp      = $clog2(total_bits_lp);
  localparam int byte_w_lp     = bit_w_lp - 3;
  localparam int addr_w_lp     = $clog2(payload_bytes_p);

  state_e                 state_q, state_d;
  logic [15:0]            id_q, id_d;
  logic [15:0]            crc_q, crc_d;
  logic [addr_w_lp-1:0]   byte_cnt_q, byte_cnt_d;
  logic [1:0]             hdr_cnt_q, hdr_cnt_d;
  logic [bit_w_lp-1:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]             sh_q, sh_d;
  logic                   miso_q, miso_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [7:0]             hdr_byte_s;
  logic [byte_w_lp-1:0]   byte_idx_s, next_idx_s, rd_off_s;
  logic [addr_w_lp-1:0]   rd_addr_s, ram_addr_s;
  logic [7:0]             rd_data_s, next_byte_s;
  logic                   ram_we_s, bit_last_s, start_go_s;

`ifdef VOSPI_DISCARD_EN
  logic pend_q, pend_d;
  assign start_go_s = start_i | pend_q;
`else
  assign start_go_s = start_i;
`endif

  assign ram_we_s   = (state_q == LOAD) && valid_i && ready_q;
  assign ram_addr_s = (state_q == LOAD) ? byte_cnt_q : rd_addr_s;

  vospi_tx_buffer #(
    .depth_p  (payload_bytes_p),
    .addr_w_p (addr_w_lp)
  ) u_buffer (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .we_i      (ram_we_s),
    .addr_i    (ram_addr_s),
    .wdata_i   (data_i),
    .rdata_o   (rd_data_s)
  );

  // Byte pointer decode; the RAM address runs one byte ahead so rd_data_s is ready at the boundary.
  always_comb begin
    byte_idx_s = bit_cnt_q[bit_w_lp-1:3];
    next_idx_s = byte_idx_s + byte_w_lp'(1);
    rd_off_s   = byte_idx_s - byte_w_lp'(3);
    bit_last_s = (bit_cnt_q == bit_w_lp'(total_bits_lp - 1));
    if ((byte_idx_s >= byte_w_lp'(3)) && (rd_off_s < byte_w_lp'(payload_bytes_p))) begin
      rd_addr_s = addr_w_lp'(rd_off_s);
    end else begin
      rd_addr_s = '0;
    end
    if (next_idx_s == byte_w_lp'(1)) begin
      next_byte_s = id_q[7:0];
    end else if (next_idx_s == byte_w_lp'(2)) begin
      next_byte_s = crc_q[15:8];
    end else if (next_idx_s == byte_w_lp'(3)) begin
      next_byte_s = crc_q[7:0];
    end else begin
      next_byte_s = rd_data_s;
    end
    case (hdr_cnt_q)
      2'd0:    hdr_byte_s = {4'h0, id_q[11:8]};
      2'd1:    hdr_byte_s = id_q[7:0];
      default: hdr_byte_s = 8'h00;
    endcase
  end

  // Next-state and next-output logic for the packet FSM.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    crc_d      = crc_q;
    byte_cnt_d = byte_cnt_q;
    hdr_cnt_d  = hdr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        sh_d      = 8'h00;
        bit_cnt_d = '0;
        if (start_go_s) begin
          state_d    = HDR;
          id_d       = start_i ? 16'(line_id_i) : id_q;
          crc_d      = 16'h0000;
          hdr_cnt_d  = 2'd0;
          byte_cnt_d = '0;
        end
`ifdef VOSPI_DISCARD_EN
        else if (!cs_n_i) begin
          state_d = DISC;
          sh_d    = discard_id_lp[15:8];
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        crc_d     = crc16_ccitt_byte(crc_q, hdr_byte_s);
        hdr_cnt_d = hdr_cnt_q + 2'd1;
        state_d   = (hdr_cnt_q == 2'd3) ? LOAD : HDR;
      end
      LOAD: begin
        if (valid_i && ready_q) begin
          crc_d      = crc16_ccitt_byte(crc_q, data_i);
          byte_cnt_d = byte_cnt_q + addr_w_lp'(1);
          if (byte_cnt_q == addr_w_lp'(payload_bytes_p - 1)) begin
            state_d    = ARMED;
            byte_cnt_d = '0;
            sh_d       = id_q[15:8];
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      ARMED: begin
        sh_d      = id_q[15:8];
        bit_cnt_d = '0;
        state_d   = cs_n_i ? ARMED : SEND;
      end
      SEND: begin
        if (cs_n_i) begin
          state_d   = ARMED;
          bit_cnt_d = '0;
          sh_d      = id_q[15:8];
        end else if (shift_i) begin
          if (bit_last_s) begin
            state_d   = IDLE;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            sh_d      = 8'h00;
          end else begin
            bit_cnt_d = bit_cnt_q + bit_w_lp'(1);
            sh_d      = (bit_cnt_q[2:0] == 3'd7) ? next_byte_s : {sh_q[6:0], 1'b0};
          end
        end else begin
          state_d = SEND;
        end
      end
`ifdef VOSPI_DISCARD_EN
      // Discard body is all zeros after 0x0F, so a plain left shift produces it.
      DISC: begin
        id_d = start_i ? 16'(line_id_i) : id_q;
        if (cs_n_i) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          sh_d      = 8'h00;
        end else if (shift_i) begin
          if (bit_last_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sh_d      = 8'h00;
          end else begin
            bit_cnt_d = bit_cnt_q + bit_w_lp'(1);
            sh_d      = {sh_q[6:0], 1'b0};
          end
        end else begin
          state_d = DISC;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == LOAD);
    busy_d  = (state_d != IDLE);
    miso_d  = ((state_d == ARMED) || (state_d == SEND) || (state_d == DISC)) ? sh_d[7] : 1'b0;
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      id_q       <= 16'h0000;
      crc_q      <= 16'h0000;
      byte_cnt_q <= '0;
      hdr_cnt_q  <= 2'd0;
      bit_cnt_q  <= '0;
      sh_q       <= 8'h00;
      miso_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      hdr_cnt_q  <= hdr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      miso_q     <= miso_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

`ifdef VOSPI_DISCARD_EN
  // A start seen during a discard is held until the block is back in IDLE.
  always_comb begin
    if ((state_q == DISC) && start_i) begin
      pend_d = 1'b1;
    end else if (state_q == IDLE) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // Pending-start flag.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  assign ready_o = ready_q;
  assign miso_o  = miso_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule

// File: tb/tb_vospi_packet_tx.sv
// Directed self-checking bench for vospi_packet_tx (discard tests built with VOSPI_DISCARD_EN).
module tb_vospi_packet_tx;

  localparam int P     = 160;
  localparam int TOTAL = 8 * (4 + P);

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        start_i = 1'b0;
  logic [11:0] line_id_i = 12'h000;
  logic [7:0]  data_i = 8'h00;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        cs_n_i = 1'b1;
  logic        shift_i = 1'b0;
  logic        miso_o;
  logic        busy_o;
  logic        done_o;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [7:0]  payload [P];
  logic        rx [TOTAL];
  logic [15:0] last_crc;
  logic [15:0] crc_ref;

  always #5 clk = ~clk;

  vospi_packet_tx #(.payload_bytes_p(P), .line_width_p(12)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .start_i   (start_i),
    .line_id_i (line_id_i),
    .data_i    (data_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .cs_n_i    (cs_n_i),
    .shift_i   (shift_i),
    .miso_o    (miso_o),
    .busy_o    (busy_o),
    .done_o    (done_o)
  );

  // Bit-serial reference CRC over header bytes then the payload array.
  function automatic logic [15:0] model_crc(input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = 16'h0000;
    for (int n = 0; n < 4 + P; n++) begin
      b = (n == 0) ? b0 : (n == 1) ? b1 : (n < 4) ? 8'h00 : payload[n-4];
      for (int j = 7; j >= 0; j--) begin
        fb = c[15] ^ b[j];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] get16(input int off);
    logic [15:0] v;
    for (int j = 0; j < 16; j++) v[15-j] = rx[off+j];
    return v;
  endfunction

  task automatic start_pkt(input logic [11:0] line);
    @(negedge clk);
    start_i = 1'b1;
    line_id_i = line;
    @(negedge clk);
    start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL hdr_ready ready=%b busy=%b want ready=0 busy=1", ready_o, busy_o); end
  endtask

  task automatic load_payload(input bit gap);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    while (k < P && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      valid_i = !(gap && cyc[0]);
      data_i = payload[k];
      if (valid_i && ready_o) k++;
    end
    @(negedge clk);
    valid_i = 1'b0;
    checks++;
    if (k != P) begin errors++; $display("FAIL load_count got %0d want %0d", k, P); end
    checks++;
    if (ready_o !== 1'b0 || busy_o !== 1'b1)
      begin errors++; $display("FAIL armed_ready ready=%b busy=%b want ready=0 busy=1", ready_o, busy_o); end
  endtask

  task automatic shift_bits(input int n, input int off);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done_o) done_cnt++;
      rx[off+i] = miso_o;
      shift_i = 1'b1;
    end
    @(negedge clk);
    shift_i = 1'b0;
    if (done_o) done_cnt++;
  endtask

  task automatic select;
    @(negedge clk);
    cs_n_i = 1'b0;
    @(negedge clk);
    done_cnt = 0;
  endtask

  task automatic check_packet(input string nm, input logic [11:0] line);
    logic [15:0] v;
    logic [15:0] crc_exp;
    logic [7:0]  got;
    int          bad;
    int          first;
    crc_exp = model_crc({4'h0, line[11:8]}, line[7:0]);
    v = get16(0);
    checks++;
    if (v !== {4'h0, line}) begin errors++; $display("FAIL %s_id got %h want %h", nm, v, {4'h0, line}); end
    v = get16(16);
    last_crc = v;
    checks++;
    if (v !== crc_exp) begin errors++; $display("FAIL %s_crc got %h want %h", nm, v, crc_exp); end
    bad = 0;
    first = -1;
    for (int k = 0; k < P; k++) begin
      for (int j = 0; j < 8; j++) got[7-j] = rx[32 + 8*k + j];
      if (got !== payload[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL %s_payload bad_bytes %0d first %0d want 0", nm, bad, first); end
  endtask

  task automatic finish_packet(input string nm);
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL %s_done count %0d want 1", nm, done_cnt); end
    checks++;
    if (busy_o !== 1'b0 || miso_o !== 1'b0)
      begin errors++; $display("FAIL %s_idle busy=%b miso=%b want 0 0", nm, busy_o, miso_o); end
    cs_n_i = 1'b1;
  endtask

  task automatic test_reset;
    #1 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, miso_o, busy_o, done_o} !== 4'b0000)
      begin errors++; $display("FAIL reset_outs got %b want 0000", {ready_o, miso_o, busy_o, done_o}); end
    repeat (3) @(negedge clk);
    reset_n_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready_o, miso_o, busy_o, done_o} !== 4'b0000)
      begin errors++; $display("FAIL post_reset got %b want 0000", {ready_o, miso_o, busy_o, done_o}); end
  endtask

  task automatic test_full_packet;
    for (int k = 0; k < P; k++) payload[k] = 8'(k);
    start_pkt(12'h005);
    load_payload(1'b0);
    select();
    shift_bits(TOTAL, 0);
    check_packet("full", 12'h005);
    crc_ref = last_crc;
    finish_packet("full");
  endtask

  task automatic test_backpressure;
    start_pkt(12'h005);
    load_payload(1'b1);
    select();
    shift_bits(TOTAL, 0);
    check_packet("bp", 12'h005);
    checks++;
    if (last_crc !== crc_ref) begin errors++; $display("FAIL bp_crc_same got %h want %h", last_crc, crc_ref); end
    finish_packet("bp");
  endtask

  task automatic test_crc_mask;
    for (int k = 0; k < P; k++) payload[k] = 8'(k) ^ 8'hA5;
    start_pkt(12'hFFF);
    load_payload(1'b0);
    select();
    shift_bits(TOTAL, 0);
    check_packet("mask", 12'hFFF);
    finish_packet("mask");
  endtask

  task automatic test_abort;
    for (int k = 0; k < P; k++) payload[k] = 8'(3*k + 7);
    start_pkt(12'h3C1);
    load_payload(1'b0);
    select();
    shift_bits(500, 0);
    cs_n_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || miso_o !== 1'b0 || done_cnt != 0)
      begin errors++; $display("FAIL abort_armed busy=%b miso=%b done=%0d want 1 0 0", busy_o, miso_o, done_cnt); end
    select();
    shift_bits(TOTAL, 0);
    check_packet("abort", 12'h3C1);
    finish_packet("abort");
  endtask

  task automatic test_async_reset;
    for (int k = 0; k < P; k++) payload[k] = 8'hFF - 8'(k);
    start_pkt(12'h123);
    load_payload(1'b0);
    select();
    shift_bits(300, 0);
    #2 reset_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, miso_o, busy_o, done_o} !== 4'b0000)
      begin errors++; $display("FAIL async_reset got %b want 0000", {ready_o, miso_o, busy_o, done_o}); end
    cs_n_i = 1'b1;
    @(negedge clk);
    reset_n_i = 1'b1;
    start_pkt(12'h0AA);
    load_payload(1'b0);
    select();
    shift_bits(TOTAL, 0);
    check_packet("rst", 12'h0AA);
    finish_packet("rst");
  endtask

`ifdef VOSPI_DISCARD_EN
  task automatic test_discard;
    int bad;
    logic [15:0] v;
    for (int k = 0; k < P; k++) payload[k] = 8'(5*k);
    select();
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL disc_busy got %b want 1", busy_o); end
    shift_bits(600, 0);
    start_i = 1'b1;
    line_id_i = 12'h0AB;
    @(negedge clk);
    start_i = 1'b0;
    shift_bits(TOTAL - 600, 600);
    cs_n_i = 1'b1;
    v = get16(0);
    checks++;
    if (v !== 16'h0F00) begin errors++; $display("FAIL disc_id got %h want 0f00", v); end
    bad = 0;
    for (int i = 16; i < TOTAL; i++) if (rx[i] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL disc_zeros ones %0d want 0", bad); end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL disc_done count %0d want 0", done_cnt); end
    load_payload(1'b0);
    select();
    shift_bits(TOTAL, 0);
    check_packet("after_disc", 12'h0AB);
    finish_packet("after_disc");
  endtask
`endif

  initial begin
    test_reset();
    test_full_packet();
    test_backpressure();
    test_crc_mask();
    test_abort();
    test_async_reset();
`ifdef VOSPI_DISCARD_EN
    test_discard();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
